// File: rtl/jump_event_queue.sv
// Jump key debouncer with frame-stamped press/release event FIFO.
// Ports: clk, reset (async low), jump_key, frame_tick, evt_pop,
//   overflow_clr -> evt_valid, evt_data, evt_count, key_interrupt, overflow.
module jump_event_queue #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        jump_key,
   input  logic        frame_tick,
   input  logic        evt_pop,
   input  logic        overflow_clr,
   output logic        evt_valid,
   output logic [16:0] evt_data,
   output logic [2:0]  evt_count,
   output logic        key_interrupt,
   output logic        overflow
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int PW = $clog2(FIFO_DEPTH);

   typedef enum logic {IDLE, COUNT} state_t;

   state_t        state, state_n;
   logic          sync1, sync2;
   logic          stable, stable_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          push;
   logic [15:0]   frame_cnt;

   logic [16:0]   mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          empty, full;
   logic          do_push, do_pop;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         stable    <= 1'b0;
         state     <= IDLE;
         cnt       <= '0;
         frame_cnt <= '0;
      end else begin
         sync1  <= jump_key;
         sync2  <= sync1;
         stable <= stable_n;
         state  <= state_n;
         cnt    <= cnt_n;
         if (frame_tick)
            frame_cnt <= frame_cnt + 16'd1;
      end
   end

   // A level change is accepted only after sync2 has disagreed with
   // stable for DEBOUNCE_CYCLES consecutive cycles.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      stable_n = stable;
      push     = 1'b0;
      unique case (state)
         IDLE: begin
            if (sync2 != stable) begin
               state_n = COUNT;
               cnt_n   = CW'(1);
            end
         end
         COUNT: begin
            if (sync2 == stable) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
               stable_n = ~stable;
               state_n  = IDLE;
               cnt_n    = '0;
               push     = 1'b1;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
      endcase
   end

   assign empty   = (evt_count == 3'd0);
   assign full    = (evt_count == 3'(FIFO_DEPTH));
   assign do_pop  = evt_pop & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++)
            mem[i] <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         evt_count <= '0;
         overflow  <= 1'b0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= {stable_n, frame_cnt};
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (do_pop)
            rd_ptr <= rd_ptr + PW'(1);
         evt_count <= evt_count + {2'b00, do_push} - {2'b00, do_pop};
         if (push & full & ~do_pop)
            overflow <= 1'b1;
         else if (overflow_clr)
            overflow <= 1'b0;
      end
   end

   assign evt_valid     = ~empty;
   assign key_interrupt = ~empty;
   assign evt_data      = empty ? 17'd0 : mem[rd_ptr];

endmodule

// File: tb/tb_jump_event_queue.sv
// Directed bench for jump_event_queue with DEBOUNCE_CYCLES = 4.
// Table of per-cycle vectors plus hand sequences for FIFO/reset corners.
module tb_jump_event_queue;
   logic        clk = 1'b0;
   logic        reset;
   logic        jump_key;
   logic        frame_tick;
   logic        evt_pop;
   logic        overflow_clr;
   logic        evt_valid;
   logic [16:0] evt_data;
   logic [2:0]  evt_count;
   logic        key_interrupt;
   logic        overflow;

   int checks   = 0;
   int failures = 0;

   jump_event_queue #(
      .DEBOUNCE_CYCLES(4),
      .FIFO_DEPTH     (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .jump_key     (jump_key),
      .frame_tick   (frame_tick),
      .evt_pop      (evt_pop),
      .overflow_clr (overflow_clr),
      .evt_valid    (evt_valid),
      .evt_data     (evt_data),
      .evt_count    (evt_count),
      .key_interrupt(key_interrupt),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        jk, ft, pop, clr;
      logic        valid;
      logic [16:0] data;
      logic [2:0]  cnt;
      logic        ovf;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic jk, logic ft, logic pop, logic clr,
                               logic valid, logic [16:0] data,
                               logic [2:0] cnt, logic ovf);
      vec_t v;
      v.jk = jk; v.ft = ft; v.pop = pop; v.clr = clr;
      v.valid = valid; v.data = data; v.cnt = cnt; v.ovf = ovf;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input logic jk, input logic ft,
                       input logic pop, input logic clr);
      jump_key     = jk;
      frame_tick   = ft;
      evt_pop      = pop;
      overflow_clr = clr;
      @(posedge clk);
      #1;
   endtask

   // Seven edges: sync1 capture, sync2, four counts, push on the last.
   task automatic transition(input logic v, input logic tick,
                             input logic pop_last, input logic clr_last);
      step(v, tick, 1'b0, 1'b0);
      repeat (5) step(v, 1'b0, 1'b0, 1'b0);
      step(v, 1'b0, pop_last, clr_last);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, " valid"}, 32'(evt_valid), 32'd0);
      chk({nm, " irq"},   32'(key_interrupt), 32'd0);
      chk({nm, " count"}, 32'(evt_count), 32'd0);
      chk({nm, " data"},  32'(evt_data), 32'd0);
      chk({nm, " ovf"},   32'(overflow), 32'd0);
   endtask

   task automatic do_reset();
      jump_key = 1'b0;
      reset    = 1'b0;
      #1;
      chk_zero("reset");
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      logic [16:0] exp_q[4];

      reset        = 1'b0;
      jump_key     = 1'b0;
      frame_tick   = 1'b0;
      evt_pop      = 1'b0;
      overflow_clr = 1'b0;
      #3;
      chk_zero("por");
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;

      // 3 ticks then clean press, pop, clean release, pop, glitch
      repeat (3) tbl.push_back(mk(0, 1, 0, 0, 0, 17'h0, 0, 0));
      repeat (6) tbl.push_back(mk(1, 0, 0, 0, 0, 17'h0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 1, 17'h10003, 1, 0));
      tbl.push_back(mk(1, 0, 1, 0, 0, 17'h0, 0, 0));
      repeat (6) tbl.push_back(mk(0, 0, 0, 0, 0, 17'h0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 17'h00003, 1, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 17'h0, 0, 0));
      repeat (3) tbl.push_back(mk(1, 0, 0, 0, 0, 17'h0, 0, 0));
      repeat (8) tbl.push_back(mk(0, 0, 0, 0, 0, 17'h0, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].jk, tbl[i].ft, tbl[i].pop, tbl[i].clr);
         chk($sformatf("vec%0d valid", i), 32'(evt_valid), 32'(tbl[i].valid));
         chk($sformatf("vec%0d irq", i), 32'(key_interrupt), 32'(tbl[i].valid));
         chk($sformatf("vec%0d data", i), 32'(evt_data), 32'(tbl[i].data));
         chk($sformatf("vec%0d count", i), 32'(evt_count), 32'(tbl[i].cnt));
         chk($sformatf("vec%0d ovf", i), 32'(overflow), 32'(tbl[i].ovf));
      end

      // Fill: {1,4} {0,5} {1,6} {0,7}
      transition(1'b1, 1'b1, 1'b0, 1'b0);
      transition(1'b0, 1'b1, 1'b0, 1'b0);
      transition(1'b1, 1'b1, 1'b0, 1'b0);
      transition(1'b0, 1'b1, 1'b0, 1'b0);
      chk("full count", 32'(evt_count), 32'd4);
      chk("full ovf", 32'(overflow), 32'd0);
      chk("full head", 32'(evt_data), 32'h10004);

      // Fifth event dropped; clear in the same cycle loses to the set
      transition(1'b1, 1'b1, 1'b0, 1'b1);
      chk("drop count", 32'(evt_count), 32'd4);
      chk("drop ovf", 32'(overflow), 32'd1);
      chk("drop head", 32'(evt_data), 32'h10004);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      chk("clr ovf", 32'(overflow), 32'd0);
      chk("clr count", 32'(evt_count), 32'd4);

      // Full with push and pop together: {0,9} enters, head advances
      transition(1'b0, 1'b1, 1'b1, 1'b0);
      chk("pp count", 32'(evt_count), 32'd4);
      chk("pp ovf", 32'(overflow), 32'd0);
      exp_q[0] = 17'h00005;
      exp_q[1] = 17'h10006;
      exp_q[2] = 17'h00007;
      exp_q[3] = 17'h00009;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("drain%0d data", i), 32'(evt_data), 32'(exp_q[i]));
         step(1'b0, 1'b0, 1'b1, 1'b0);
      end
      chk_zero("drained");
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk_zero("pop empty");

      // Push and pop together while empty: pop has no effect
      transition(1'b1, 1'b1, 1'b1, 1'b0);
      chk("pp empty count", 32'(evt_count), 32'd1);
      chk("pp empty data", 32'(evt_data), 32'h1000A);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      chk("pp empty drain", 32'(evt_count), 32'd0);

      // Frame counter wrap
      do_reset();
      repeat (65536) step(1'b0, 1'b1, 1'b0, 1'b0);
      transition(1'b1, 1'b0, 1'b0, 1'b0);
      chk("wrap count", 32'(evt_count), 32'd1);
      chk("wrap data", 32'(evt_data), 32'h10000);

      // Reset in the middle of a debounce count
      do_reset();
      step(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      #1;
      chk_zero("mid reset");
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0);
         chk($sformatf("post rst edge%0d valid", i), 32'(evt_valid), 32'd0);
      end
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("post rst valid", 32'(evt_valid), 32'd1);
      chk("post rst data", 32'(evt_data), 32'h10000);
      chk("post rst count", 32'(evt_count), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
